// File: rtl/candy_avb_mem_pkg.sv
// Shared constants for the CANDY AVB on-chip RAM arbiter.
package candy_avb_mem_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int PORT_CPU   = 0;
  localparam int PORT_DMA   = 1;
  localparam int NUM_PORTS  = 2;
  localparam int CNT_W      = 4;
endpackage

// File: rtl/candy_avb_onchip_mem_arbiter_if.sv
// One Avalon-MM master command/response bundle.
interface candy_avb_onchip_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/candy_avb_wrr2_grant.sv
// Two-requester weighted round-robin: port 1 may win up to W1 times in a
// row against a competing port 0, then port 0 gets one grant.
module candy_avb_wrr2_grant
  import candy_avb_mem_pkg::*;
#(
  parameter int W1 = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);
  localparam logic [CNT_W-1:0] W1_C = CNT_W'(W1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Grant decision; held off entirely while reset is asserted so every
  // master sees waitrequest immediately.
  always_comb begin
    gnt = '0;
    if (reset_n) begin
      if (&req) begin
        gnt[PORT_DMA] = (cnt_q < W1_C);
        gnt[PORT_CPU] = !(cnt_q < W1_C);
      end else begin
        gnt = req;
      end
    end
  end

  // Weight counter: cleared by a CPU win, saturating count of DMA wins.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt[PORT_CPU])                       cnt_d = '0;
    else if (gnt[PORT_DMA] && cnt_q < W1_C)  cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/candy_avb_onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between the Nios II data master (m0)
// and the AVB audio DMA master (m1). Commands are muxed combinationally;
// the 1-cycle read return is steered by a registered owner bit.
module candy_avb_onchip_mem_arbiter
  import candy_avb_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int W1     = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  candy_avb_onchip_mem_arbiter_if.slave m0,
  candy_avb_onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  logic [NUM_PORTS-1:0] req, gnt;
  logic                 rd_fire;
  logic                 rd_pend_q, rd_pend_d;
  logic                 rd_owner_q, rd_owner_d;

  assign req[PORT_CPU] = m0.read | m0.write;
  assign req[PORT_DMA] = m1.read | m1.write;

  candy_avb_wrr2_grant #(.W1(W1)) u_grant (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt)
  );

  // Command mux; with no grant the CPU port values pass through with the
  // strobes low so the RAM pins stay deterministic.
  always_comb begin
    mem_chipselect = |gnt;
    mem_address    = m0.address;
    mem_byteenable = m0.byteenable;
    mem_writedata  = m0.writedata;
    mem_write      = gnt[PORT_CPU] & m0.write;
    if (gnt[PORT_DMA]) begin
      mem_address    = m1.address;
      mem_byteenable = m1.byteenable;
      mem_writedata  = m1.writedata;
      mem_write      = m1.write;
    end
  end

  assign mem_clken      = 1'b1;
  assign m0.waitrequest = ~gnt[PORT_CPU];
  assign m1.waitrequest = ~gnt[PORT_DMA];

  // A read is a granted read strobe without write (read+write is a write).
  always_comb begin
    rd_fire    = (gnt[PORT_CPU] & m0.read & ~m0.write) |
                 (gnt[PORT_DMA] & m1.read & ~m1.write);
    rd_pend_d  = rd_fire;
    rd_owner_d = rd_fire ? gnt[PORT_DMA] : rd_owner_q;
  end

  // Read-owner pipeline; async clear drops any in-flight return at reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = rd_pend_q & ~rd_owner_q;
  assign m1.readdatavalid = rd_pend_q &  rd_owner_q;
endmodule

// File: tb/tb_candy_avb_onchip_mem_arbiter.sv
// Bench for the on-chip RAM arbiter: RAM model, directed table, corner
// sequences and constrained-random traffic against a behavioural model.
module tb_candy_avb_onchip_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int W1 = 4;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wd;
  } cmd_t;

  typedef struct {
    cmd_t c0;
    cmd_t c1;
    logic ew0;
    logic ew1;
    logic ecs;
    logic ewe;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic tb_load;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;

  candy_avb_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  candy_avb_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

  candy_avb_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .W1(W1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] preload(int i);
    if (i == 5)     return 32'hDEADBEEF;
    if (i == 1023)  return 32'hCAFEF00D;
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Single-port RAM with 1-cycle registered read.
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 1024; i++) ram[i] <= preload(i);
    end else if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Reference model state.
  logic [DW-1:0] ram_ref [1024];
  int            m_run;      // consecutive DMA wins, capped at W1
  logic [1:0]    exp_rv;
  logic [DW-1:0] exp_rd;

  int n_vec = 0;
  int n_bad = 0;

  logic          last_w0, last_w1, last_rv0, last_rv1;
  logic [1:0]    last_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk_idle();
    cmd_t c;
    c.rd = 0; c.wr = 0; c.addr = '0; c.be = '0; c.wd = '0;
    return c;
  endfunction

  function automatic cmd_t mk_rd(logic [AW-1:0] a);
    cmd_t c = mk_idle();
    c.rd = 1; c.addr = a; c.be = 4'hF;
    return c;
  endfunction

  function automatic cmd_t mk_wr(logic [AW-1:0] a, logic [3:0] be, logic [DW-1:0] wd, logic also_rd);
    cmd_t c = mk_idle();
    c.wr = 1; c.rd = also_rd; c.addr = a; c.be = be; c.wd = wd;
    return c;
  endfunction

  function automatic cmd_t mk_rand();
    cmd_t c = mk_idle();
    int k = $urandom_range(0, 3);
    c.rd   = (k == 1) || (k == 3);
    c.wr   = (k >= 2);
    c.addr = ($urandom_range(0, 3) == 0) ? 10'(1016 + $urandom_range(0, 7))
                                         : 10'($urandom_range(0, 7));
    c.be   = 4'($urandom_range(0, 15));
    c.wd   = $urandom;
    return c;
  endfunction

  // Winner per the weighting rule: DMA wins a contest until it has won W1
  // in a row, then the CPU gets its turn.
  function automatic logic [1:0] model_gnt(cmd_t c0, cmd_t c1);
    logic q0 = c0.rd | c0.wr;
    logic q1 = c1.rd | c1.wr;
    if (q0 && q1) return (m_run < W1) ? 2'b10 : 2'b01;
    return {q1, q0};
  endfunction

  task automatic drive(input cmd_t c0, input cmd_t c1);
    m0_if.read = c0.rd; m0_if.write = c0.wr; m0_if.address = c0.addr;
    m0_if.byteenable = c0.be; m0_if.writedata = c0.wd;
    m1_if.read = c1.rd; m1_if.write = c1.wr; m1_if.address = c1.addr;
    m1_if.byteenable = c1.be; m1_if.writedata = c1.wd;
  endtask

  // One clock: called just after a rising edge, checks at the falling edge,
  // advances the model, returns just after the next rising edge.
  task automatic step(input cmd_t c0, input cmd_t c1, input string tag);
    logic [1:0] g;
    cmd_t cg;
    drive(c0, c1);
    @(negedge clk);
    g = model_gnt(c0, c1);
    last_g = g;
    last_w0 = m0_if.waitrequest;  last_w1 = m1_if.waitrequest;
    last_rv0 = m0_if.readdatavalid; last_rv1 = m1_if.readdatavalid;
    chk({tag, ".wait0"}, 32'(m0_if.waitrequest), 32'(!g[0]));
    chk({tag, ".wait1"}, 32'(m1_if.waitrequest), 32'(!g[1]));
    chk({tag, ".cs"},    32'(mem_chipselect),    32'(g != 0));
    chk({tag, ".rdv0"},  32'(m0_if.readdatavalid), 32'(exp_rv[0]));
    chk({tag, ".rdv1"},  32'(m1_if.readdatavalid), 32'(exp_rv[1]));
    if (exp_rv[0]) chk({tag, ".rdata0"}, m0_if.readdata, exp_rd);
    if (exp_rv[1]) chk({tag, ".rdata1"}, m1_if.readdata, exp_rd);
    exp_rv = 2'b00;
    if (g != 0) begin
      cg = g[1] ? c1 : c0;
      chk({tag, ".we"},   32'(mem_write),   32'(cg.wr));
      chk({tag, ".addr"}, 32'(mem_address), 32'(cg.addr));
      if (cg.wr) begin
        for (int b = 0; b < 4; b++)
          if (cg.be[b]) ram_ref[cg.addr][8*b +: 8] = cg.wd[8*b +: 8];
      end else begin
        exp_rv[g[1]] = 1'b1;
        exp_rd = ram_ref[cg.addr];
      end
      if (g[0]) m_run = 0;
      else if (m_run < W1) m_run++;
    end else begin
      chk({tag, ".we_idle"}, 32'(mem_write), 32'(0));
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic load);
    reset_n = 1'b0;
    tb_load = load;
    drive(mk_idle(), mk_idle());
    m_run = 0; exp_rv = 2'b00;
    if (load) for (int i = 0; i < 1024; i++) ram_ref[i] = preload(i);
    @(negedge clk);
    chk("rst.wait0", 32'(m0_if.waitrequest), 32'(1));
    chk("rst.wait1", 32'(m1_if.waitrequest), 32'(1));
    chk("rst.rdv0",  32'(m0_if.readdatavalid), 32'(0));
    chk("rst.rdv1",  32'(m1_if.readdatavalid), 32'(0));
    chk("rst.cs",    32'(mem_chipselect), 32'(0));
    chk("rst.clken", 32'(mem_clken), 32'(1));
    tb_load = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  vec_t tbl [10];

  initial begin
    cmd_t c0, c1;

    tbl[0] = '{mk_idle(),               mk_idle(),          1, 1, 0, 0};
    tbl[1] = '{mk_rd(10'h005),          mk_idle(),          0, 1, 1, 0};
    tbl[2] = '{mk_rd(10'h010),          mk_rd(10'h011),     1, 0, 1, 0};
    tbl[3] = '{mk_idle(),               mk_wr(10'h012, 4'hF, 32'h1111_2222, 0), 1, 0, 1, 1};
    tbl[4] = '{mk_rd(10'h012),          mk_rd(10'h013),     1, 0, 1, 0};
    tbl[5] = '{mk_rd(10'h012),          mk_rd(10'h014),     1, 0, 1, 0};
    tbl[6] = '{mk_wr(10'h015, 4'h5, 32'hAABB_CCDD, 0), mk_rd(10'h015), 0, 1, 1, 1};
    tbl[7] = '{mk_wr(10'h016, 4'hF, 32'h0F0F_0F0F, 1), mk_idle(), 0, 1, 1, 1};
    tbl[8] = '{mk_rd(10'h016),          mk_rd(10'h015),     1, 0, 1, 0};
    tbl[9] = '{mk_idle(),               mk_idle(),          1, 1, 0, 0};

    do_reset(1'b1);

    // Directed table from a fresh counter.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].c0, tbl[i].c1, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.w0", i), 32'(last_w0), 32'(tbl[i].ew0));
      chk($sformatf("tbl%0d.w1", i), 32'(last_w1), 32'(tbl[i].ew1));
      if (i == 8) chk("rw_no_rdv0", 32'(last_rv0), 32'(0));
    end

    // Single CPU read of the preloaded word.
    do_reset(1'b0);
    step(mk_rd(10'h005), mk_idle(), "cpu_rd");
    chk("cpu_rd.same_cycle_gnt", 32'(last_w0), 32'(0));
    step(mk_idle(), mk_idle(), "cpu_rd_ret");
    chk("cpu_rd.rdv0", 32'(last_rv0), 32'(1));
    chk("cpu_rd.rdv1", 32'(last_rv1), 32'(0));
    chk("cpu_rd.data", m0_if.readdata, 32'hDEADBEEF);

    // Contended reads: 1,1,1,1,0 repeating with no bubbles.
    do_reset(1'b0);
    for (int i = 0; i < 15; i++) begin
      step(mk_rd(10'(32 + i)), mk_rd(10'(64 + i)), $sformatf("wrr%0d", i));
      chk($sformatf("wrr%0d.pattern", i), 32'(last_w1), 32'((i % 5) == 4));
      if (i > 0) chk($sformatf("wrr%0d.one_rdv", i), 32'(last_rv0 + last_rv1), 32'(1));
    end
    step(mk_idle(), mk_idle(), "wrr_drain");

    // Partial write by CPU then DMA read of the same word.
    step(mk_wr(10'h3FF, 4'b0011, 32'h1234_5678, 0), mk_idle(), "pw_wr");
    step(mk_idle(), mk_rd(10'h3FF), "pw_rd");
    step(mk_idle(), mk_idle(), "pw_ret");
    chk("pw.rdv1", 32'(last_rv1), 32'(1));
    chk("pw.data", m1_if.readdata, 32'hCAFE_5678);

    // DMA alone saturates the counter; CPU then wins immediately.
    for (int i = 0; i < 10; i++) step(mk_idle(), mk_rd(10'(i)), "dma_solo");
    step(mk_rd(10'h007), mk_rd(10'h008), "cpu_after_sat");
    chk("cpu_after_sat.gnt0", 32'(last_w0), 32'(0));
    step(mk_idle(), mk_idle(), "sat_drain");

    // Reset landing on an in-flight DMA read return.
    step(mk_idle(), mk_rd(10'h020), "pre_rst");
    chk("pre_rst.rdv1", 32'(m1_if.readdatavalid), 32'(1));
    drive(mk_rd(10'h001), mk_rd(10'h002));
    reset_n = 1'b0;
    #1;
    chk("async_rst.rdv1",  32'(m1_if.readdatavalid), 32'(0));
    chk("async_rst.wait0", 32'(m0_if.waitrequest), 32'(1));
    chk("async_rst.wait1", 32'(m1_if.waitrequest), 32'(1));
    chk("async_rst.cs",    32'(mem_chipselect), 32'(0));
    m_run = 0; exp_rv = 2'b00;
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(mk_rd(10'h001), mk_rd(10'h002), "post_rst");
    chk("post_rst.gnt1", 32'(last_w1), 32'(0));
    step(mk_idle(), mk_idle(), "post_rst_drain");

    // Random traffic; a master holds its command until granted.
    c0 = mk_rand(); c1 = mk_rand();
    for (int i = 0; i < 400; i++) begin
      step(c0, c1, "rnd");
      if (last_g[0] || !(c0.rd | c0.wr)) c0 = mk_rand();
      if (last_g[1] || !(c1.rd | c1.wr)) c1 = mk_rand();
    end
    step(mk_idle(), mk_idle(), "rnd_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/candy_avb_onchip_mem_arbiter.md
# candy_avb_onchip_mem_arbiter

Two-port Avalon-MM arbiter that shares the single-port 1024x32 on-chip RAM of the CANDY AVB Qsys system between the Nios II data master (port 0) and the AVB audio DMA master (port 1). It grants at most one transaction per clock to the RAM. It steers the fixed 1-cycle read data back to the port that issued the read. It applies a weighted round-robin that favours the audio stream without starving the CPU.

## Interface
Parameters:
- ADDR_W, 10: word-address width of the RAM.
- DATA_W, 32: data width; byteenable width is DATA_W/8.
- W1, 4: maximum consecutive port-1 grants while port 0 is also requesting (range 1..15).

Ports:
- clk  in  1  system clock; all logic is in this single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- m0_address / m1_address  in  ADDR_W  word address.
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes for writes.
- m0_read, m0_write / m1_read, m1_write  in  1  request strobes; read and write together count as a write.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_waitrequest / m1_waitrequest  out  1  high when the command is not accepted this cycle.
- m0_readdata / m1_readdata  out  DATA_W  read return; both carry mem_readdata.
- m0_readdatavalid / m1_readdatavalid  out  1  read return qualifier for the port.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  DATA_W/8  RAM byte lanes.
- mem_chipselect, mem_write  out  1  RAM strobes.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable; tied to 1.
- mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after the address.

## Operation
- req_x = mX_read | mX_write.
- Grant (combinational, from current requests and state):
  - Neither port requesting: no grant.
  - One port requesting: grant that port.
  - Both requesting: if cnt < W1, grant port 1; otherwise grant port 0.
- cnt, 4-bit weight counter, updated each cycle:
  - Cleared on any port-0 grant.
  - Incremented on a port-1 grant, saturating at W1.
  - Unchanged on idle cycles.
- Granted port:
  - mX_waitrequest = 0.
  - mem_chipselect = 1, mem_write = mX_write, and address, byteenable and writedata are muxed from that port.
- All other ports: waitrequest = 1, including idle ports.
- No grant:
  - mem_chipselect = 0, mem_write = 0.
  - mem_address, byteenable and writedata hold port-0 values; this is don't-care but deterministic.
- Read tracking:
  - rd_pend, 1 bit, and rd_owner, 1 bit, are registered on any granted read (grant with mX_read=1 and mX_write=0).
  - Next cycle: mX_readdatavalid = rd_pend & (rd_owner == X).
- Writes produce no readdatavalid.
- Reset (reset_n low, asynchronous):
  - cnt = 0, rd_pend = 0, rd_owner = 0.
  - Every readdatavalid = 0 immediately, and every waitrequest = 1.
  - A read accepted in the cycle reset asserts never returns.

## Timing
- Command acceptance has zero added latency: a request is granted in the cycle it is presented.
- Read latency is exactly 1 cycle: read accepted in cycle N gives readdatavalid in N+1.
- Back-to-back reads, including alternating ports, sustain 1 per cycle with no bubble.
- Simultaneous read and write to the same address from different ports are serialised by grant order. Read-during-write data from the RAM is don't-care.
- Outputs after reset release:
  - m0/m1_waitrequest = 1 when idle.
  - mX_readdatavalid = 0.
  - mem_chipselect = 0, mem_write = 0.
  - mem_clken = 1.
- Masters must hold a command stable while their waitrequest is high (Avalon rule). The arbiter does not latch commands.

## Structure
- Shared package candy_avb_mem_pkg holds:
  - default ADDR_W / DATA_W;
  - the port index constants PORT_CPU=0 and PORT_DMA=1;
  - CNT_W=4.
- Sub-module candy_avb_wrr2_grant holds the two-requester weighted grant logic and cnt register.
- Top level holds the command mux and the read-owner pipeline.

## Test plan
- Reset, then a single m0 read of address 0x005 with the RAM preloaded to 0xDEADBEEF → m0_waitrequest=0 in the same cycle; m0_readdatavalid=1 with 0xDEADBEEF one cycle later; m1_readdatavalid stays 0.
- Both ports reading continuously with W1=4 → grant sequence 1,1,1,1,0,1,1,1,1,0…; each readdatavalid appears on the correct port exactly one cycle after its grant.
- m0 writes 0x12345678 with byteenable 4'b0011 to 0x3FF, then m1 reads 0x3FF → m1 reads 0xXXXX5678, where the upper half is the preload value.
- m1 requests alone for 10 cycles (cnt saturates at 4), then m0 requests → m0 is granted in its first request cycle.
- reset_n pulled low in the cycle after an accepted m1 read → m1_readdatavalid=0 asynchronously and both waitrequests are 1; after release the first both-request cycle grants port 1 (cnt=0).
- Port with read and write both asserted → treated as a write; no readdatavalid follows.
